// File: rtl/bus_arbiter.sv
// Round-robin arbiter for four bus masters; the owner register parks on the last owner when idle.
// Define BUS_ARB_TIMEOUT_EN to force rotation after MAX_TENURE owned cycles when others wait.
module bus_arbiter #(
    parameter int unsigned MAX_TENURE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0Req_,
    input  logic       m1Req_,
    input  logic       m2Req_,
    input  logic       m3Req_,
    output logic       m0Grnt_,
    output logic       m1Grnt_,
    output logic       m2Grnt_,
    output logic       m3Grnt_,
    output logic [1:0] busOwner
);

    localparam int unsigned N_MASTERS = 4;

    if (MAX_TENURE < 2 || MAX_TENURE > 256) begin : g_tenure_range
        $error("bus_arbiter: MAX_TENURE must be in 2..256");
    end

    typedef enum logic [1:0] {
        OWNER_0 = 2'd0,
        OWNER_1 = 2'd1,
        OWNER_2 = 2'd2,
        OWNER_3 = 2'd3
    } owner_t;

    owner_t                 state;
    owner_t                 state_nxt;
    logic [N_MASTERS-1:0]   req;
    logic [N_MASTERS-1:0]   others_req;
    logic [N_MASTERS-1:0]   grnt_n;
    logic                   rotate;

    assign req = {~m3Req_, ~m2Req_, ~m1Req_, ~m0Req_};
    assign others_req = req & ~(N_MASTERS'(1) << state);

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [7:0] TENURE_LAST = 8'(MAX_TENURE - 1);

    logic [7:0] tenure;

    // Owned-cycle counter; cleared on every hand-over, saturates at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tenure <= '0;
        end else if (state_nxt != state) begin
            tenure <= '0;
        end else if (tenure != TENURE_LAST) begin
            tenure <= tenure + 8'd1;
        end
    end
`endif

    // State register; grants are registered from the same next state so they never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= OWNER_0;
            grnt_n <= 4'b1110;
        end else begin
            state  <= state_nxt;
            grnt_n <= ~(N_MASTERS'(1) << state_nxt);
        end
    end

    // Next owner: hold while the owner requests, otherwise first requester after the owner.
    always_comb begin
        state_nxt = state;
        rotate    = ~req[state];
`ifdef BUS_ARB_TIMEOUT_EN
        if (tenure == TENURE_LAST && |others_req) begin
            rotate = 1'b1;
        end
`endif
        if (rotate) begin
            // Walk from the farthest candidate back so the nearest requester wins.
            for (int k = N_MASTERS - 1; k >= 1; k--) begin
                if (others_req[2'(state + 2'(k))]) begin
                    state_nxt = owner_t'(2'(state + 2'(k)));
                end
            end
        end
    end

    assign busOwner = state;
    assign m0Grnt_  = grnt_n[0];
    assign m1Grnt_  = grnt_n[1];
    assign m2Grnt_  = grnt_n[2];
    assign m3Grnt_  = grnt_n[3];

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed scenarios plus random requests against a reference model.
module tb_bus_arbiter;

    localparam int TENURE = 4;

    logic       clk;
    logic       reset;
    logic       m0Req_, m1Req_, m2Req_, m3Req_;
    logic       m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_;
    logic [1:0] busOwner;

    int total = 0;
    int bad   = 0;

    int    exp_q[$];
    string tag_q[$];

    int m_owner  = 0;
    int m_tenure = 0;

    int rr_exp[4] = '{2, 3, 0, 1};

    bus_arbiter #(.MAX_TENURE(TENURE)) dut (
        .clk     (clk),
        .reset   (reset),
        .m0Req_  (m0Req_),
        .m1Req_  (m1Req_),
        .m2Req_  (m2Req_),
        .m3Req_  (m3Req_),
        .m0Grnt_ (m0Grnt_),
        .m1Grnt_ (m1Grnt_),
        .m2Grnt_ (m2Grnt_),
        .m3Grnt_ (m3Grnt_),
        .busOwner(busOwner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: owner keeps the bus while requesting; on release the nearest requester
    // after it in rotation order takes over; nobody waiting means the owner stays parked.
    function automatic void model_step(input logic [3:0] rn);
        bit give_up;
        bit found;
        int cand;
        give_up = (rn[2'(m_owner)] == 1'b1);
`ifdef BUS_ARB_TIMEOUT_EN
        if (m_tenure == TENURE - 1 && (rn | (4'b0001 << m_owner)) != 4'b1111) give_up = 1'b1;
`endif
        cand  = m_owner;
        found = 1'b0;
        if (give_up) begin
            for (int k = 1; k < 4; k++) begin
                if (!found && rn[2'((m_owner + k) % 4)] == 1'b0) begin
                    cand  = (m_owner + k) % 4;
                    found = 1'b1;
                end
            end
        end
        if (cand != m_owner) begin
            m_owner  = cand;
            m_tenure = 0;
        end else if (m_tenure < TENURE - 1) begin
            m_tenure = m_tenure + 1;
        end
    endfunction

    task automatic check_bus(input string name, input int exp_owner);
        logic [3:0] g;
        logic [3:0] eg;
        g  = {m3Grnt_, m2Grnt_, m1Grnt_, m0Grnt_};
        eg = ~(4'(4'b0001 << exp_owner));
        total++;
        if (busOwner !== 2'(exp_owner)) begin
            bad++;
            $display("FAIL %s busOwner actual=%0d required=%0d t=%0t", name, busOwner, exp_owner, $time);
        end
        total++;
        if (g !== eg) begin
            bad++;
            $display("FAIL %s grants_n actual=%b required=%b t=%0t", name, g, eg, $time);
        end
    endtask

    task automatic drive(input logic [3:0] rn, input string name);
        @(negedge clk);
        {m3Req_, m2Req_, m1Req_, m0Req_} = rn;
        model_step(rn);
        exp_q.push_back(m_owner);
        tag_q.push_back(name);
    endtask

    task automatic spot(input string name, input int exp_owner);
        @(posedge clk);
        #2;
        check_bus(name, exp_owner);
    endtask

    // Monitor: after every active edge compare the DUT against the oldest pending expectation.
    always @(posedge clk) begin
        int    e;
        string t;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_bus(t, e);
        end
    end

    initial begin
        logic [3:0] rn;
        reset = 1'b1;
        {m3Req_, m2Req_, m1Req_, m0Req_} = 4'b1111;
        @(negedge clk);
        check_bus("reset_state", 0);
        reset = 1'b0;
        m_owner  = 0;
        m_tenure = 0;

        // Hold then release to the waiting master 2.
        for (int i = 0; i < 5; i++) drive(4'b1010, "hold");
        drive(4'b1011, "release");
        spot("release_spot", 2);

        // Reach owner 1, then everyone requests and each owner drops after one cycle.
        drive(4'b1101, "to_owner1");
        spot("to_owner1_spot", 1);
        for (int i = 0; i < 4; i++) begin
            drive(4'(4'b0001 << m_owner), "round_robin");
            spot("round_robin_spot", rr_exp[i]);
        end

        // Parking on owner 3, then a lone requester.
        drive(4'b0111, "to_owner3");
        for (int i = 0; i < 10; i++) begin
            drive(4'b1111, "park");
            spot("park_spot", 3);
        end
        drive(4'b1101, "unpark");
        spot("unpark_spot", 1);

        // Wrap-around priority: from 3, master 0 beats master 2.
        drive(4'b0111, "to_owner3b");
        drive(4'b1010, "wrap");
        spot("wrap_spot", 0);

        // Master 1 holds forever while master 3 waits.
        drive(4'b1101, "to_owner1b");
        for (int i = 1; i <= 100; i++) begin
            drive(4'b0101, "tenure");
            if (i == 3) spot("tenure_pre", 1);
`ifdef BUS_ARB_TIMEOUT_EN
            else if (i == 4) spot("tenure_force", 3);
`else
            else if (i == 4 || i == 100) spot("tenure_hold", 1);
`endif
        end

        // Asynchronous reset in the middle of a cycle while master 2 owns the bus.
        drive(4'b1011, "to_owner2");
        spot("to_owner2_spot", 2);
        #1;
        reset = 1'b1;
        #1;
        check_bus("reset_async", 0);
        @(posedge clk);
        #1;
        check_bus("reset_held", 0);
        @(negedge clk);
        reset = 1'b0;
        m_owner  = 0;
        m_tenure = 0;
        #1;
        check_bus("reset_release", 0);
        drive(4'b1011, "post_reset");

        // Random traffic with occasional mid-cycle reset pulses.
        for (int i = 0; i < 600; i++) begin
            rn = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) rn[2'(m_owner)] = 1'b0;
            drive(rn, "random");
            if ($urandom_range(0, 49) == 0) begin
                @(posedge clk);
                #3;
                reset = 1'b1;
                #1;
                check_bus("random_reset", 0);
                reset = 1'b0;
                m_owner  = 0;
                m_tenure = 0;
            end
        end

        repeat (2) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
